// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: byte-stream command bridge between a UART byte engine
// and NCH channels of DW-bit debug in/out words.
module uart_cmd_bridge #(
    parameter int NCH     = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic [NCH*DW-1:0] in_pins,
    output logic [NCH*DW-1:0] out_pins,
    output logic [NCH-1:0]    out_wr_stb,
    output logic              out_clk,
    output logic              out_rst,
    output logic              busy,
    output logic              rx_overrun
);
    localparam int NB = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST = 4'(NB - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [7:0]    ACK  = 8'hA5;
    localparam logic [7:0]    ERR  = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_DATA,
        EXEC,
        SEND
    } state_t;

    state_t        state;
    logic [7:0]    op;
    logic [7:0]    ch;
    logic [DW-1:0] data_buf;
    logic [DW-1:0] reply_buf;
    logic [3:0]    byte_cnt;
    logic [3:0]    remain;
    logic [TW-1:0] tmo;

    logic          ch_ok;
    logic          need_ch;
    logic          do_write;
    logic [DW-1:0] in_sel;
    logic [DW-1:0] out_sel;
    logic [DW-1:0] exec_word;
    logic [DW-1:0] reply_nxt;
    logic [3:0]    exec_len;

    assign busy      = (state != IDLE);
    assign ch_ok     = ({1'b0, ch} < 9'(NCH));
    assign need_ch   = (rx_data == 8'h20) || (rx_data == 8'h30) ||
                       (rx_data == 8'h31);
    assign reply_nxt = reply_buf >> 8;

    always_comb begin
        in_sel  = '0;
        out_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(ch) == c) begin
                in_sel  = in_pins[c*DW +: DW];
                out_sel = out_pins[c*DW +: DW];
            end
        end
    end

    // Reply word is the full snapshot; SEND shifts it out LSB byte first.
    always_comb begin
        exec_word = DW'(ERR);
        exec_len  = 4'd1;
        do_write  = 1'b0;
        case (op)
            8'h10, 8'h11, 8'h12, 8'h13: exec_word = DW'(ACK);
            8'h20: begin
                if (ch_ok) begin
                    exec_word = in_sel;
                    exec_len  = 4'(NB);
                end
            end
            8'h30: begin
                if (ch_ok) begin
                    exec_word = DW'(ACK);
                    do_write  = 1'b1;
                end
            end
            8'h31: begin
                if (ch_ok) begin
                    exec_word = out_sel;
                    exec_len  = 4'(NB);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            op         <= '0;
            ch         <= '0;
            data_buf   <= '0;
            reply_buf  <= '0;
            byte_cnt   <= '0;
            remain     <= '0;
            tmo        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            out_pins   <= '0;
            out_wr_stb <= '0;
            out_clk    <= 1'b0;
            out_rst    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            out_wr_stb <= '0;
            rx_overrun <= rx_valid && (state == EXEC || state == SEND);
            case (state)
                IDLE: begin
                    tmo <= '0;
                    if (rx_valid) begin
                        op       <= rx_data;
                        byte_cnt <= '0;
                        unique case (1'b1)
                            (rx_data == 8'h00): state <= IDLE;
                            need_ch:            state <= GET_CH;
                            default:            state <= EXEC;
                        endcase
                    end
                end
                GET_CH, GET_DATA: begin
                    if (rx_valid) begin
                        tmo <= '0;
                        if (state == GET_CH) begin
                            ch    <= rx_data;
                            state <= (op == 8'h30) ? GET_DATA : EXEC;
                        end else begin
                            data_buf <= (data_buf >> 8) |
                                        (DW'(rx_data) << (DW - 8));
                            byte_cnt <= byte_cnt + 4'd1;
                            if (byte_cnt == LAST) state <= EXEC;
                        end
                    end else if (tmo == TMAX) begin
                        tmo   <= '0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                EXEC: begin
                    case (op)
                        8'h10:   out_clk <= 1'b1;
                        8'h11:   out_clk <= 1'b0;
                        8'h12:   out_rst <= 1'b1;
                        8'h13:   out_rst <= 1'b0;
                        default: ;
                    endcase
                    if (do_write) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (int'(ch) == c) begin
                                out_pins[c*DW +: DW] <= data_buf;
                                out_wr_stb[c]        <= 1'b1;
                            end
                        end
                    end
                    reply_buf <= exec_word;
                    tx_data   <= exec_word[7:0];
                    remain    <= exec_len;
                    tx_valid  <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (remain == 4'd1) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            remain    <= remain - 4'd1;
                            reply_buf <= reply_nxt;
                            tx_data   <= reply_nxt[7:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed and randomized frames against a
// behavioural model of the command bridge.
`timescale 1ns/1ps
module tb_uart_cmd_bridge;
    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int TMO = 40;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b0;
    logic [NCH*DW-1:0] in_pins = '0;
    logic [NCH*DW-1:0] out_pins;
    logic [NCH-1:0]    out_wr_stb;
    logic              out_clk;
    logic              out_rst;
    logic              busy;
    logic              rx_overrun;

    uart_cmd_bridge #(.NCH(NCH), .DW(DW), .TIMEOUT(TMO)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .in_pins    (in_pins),
        .out_pins   (out_pins),
        .out_wr_stb (out_wr_stb),
        .out_clk    (out_clk),
        .out_rst    (out_rst),
        .busy       (busy),
        .rx_overrun (rx_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 2;
    bit run_cmp = 1'b0;

    logic [DW-1:0]  m_out [NCH];
    logic           m_clk = 1'b0;
    logic           m_rst = 1'b0;
    logic [NCH-1:0] exp_stb = '0;
    logic           exp_ovr = 1'b0;
    logic [7:0]     exp_q [$];

    task automatic chk(input string name, input logic [NCH*DW-1:0] act,
                       input logic [NCH*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [NCH*DW-1:0] m_pack();
        logic [NCH*DW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*DW +: DW] = m_out[c];
        return v;
    endfunction

    function automatic logic [DW-1:0] q_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = exp_q[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_out[c] = '0;
        m_clk = 1'b0;
        m_rst = 1'b0;
        exp_stb = '0;
        exp_ovr = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        for (int i = 0; i < NB; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    // Effect of one complete frame, straight from the command table.
    task automatic model_apply(input logic [7:0] op, input logic [7:0] ch,
                               input logic [DW-1:0] d);
        bit ok;
        ok = (int'(ch) < NCH);
        case (op)
            8'h10: begin m_clk = 1'b1; exp_q.push_back(8'hA5); end
            8'h11: begin m_clk = 1'b0; exp_q.push_back(8'hA5); end
            8'h12: begin m_rst = 1'b1; exp_q.push_back(8'hA5); end
            8'h13: begin m_rst = 1'b0; exp_q.push_back(8'hA5); end
            8'h20: begin
                if (ok) push_word(in_pins[int'(ch)*DW +: DW]);
                else exp_q.push_back(8'hEE);
            end
            8'h30: begin
                if (ok) begin
                    m_out[ch] = d;
                    exp_stb = NCH'(1) << ch;
                    exp_q.push_back(8'hA5);
                end else begin
                    exp_q.push_back(8'hEE);
                end
            end
            8'h31: begin
                if (ok) push_word(m_out[ch]);
                else exp_q.push_back(8'hEE);
            end
            8'h00: ;
            default: exp_q.push_back(8'hEE);
        endcase
    endtask

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0: tx_ready = ($urandom_range(0, 3) != 0);
            1: tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    always @(negedge sys_clk) begin
        if (run_cmp) begin
            chk("tx_valid", tx_valid, exp_q.size() != 0);
            if (tx_valid && exp_q.size() != 0) begin
                chk("tx_data", tx_data, exp_q[0]);
                if (tx_ready) void'(exp_q.pop_front());
            end
            chk("out_pins", out_pins, m_pack());
            chk("out_clk", out_clk, m_clk);
            chk("out_rst", out_rst, m_rst);
            chk("out_wr_stb", out_wr_stb, exp_stb);
            exp_stb = '0;
            chk("rx_overrun", rx_overrun, exp_ovr);
            exp_ovr = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] ch,
                             input logic [DW-1:0] d, input int gmax);
        logic [7:0] b [6];
        int n;
        b[0] = op;
        b[1] = ch;
        for (int i = 0; i < NB; i++) b[2+i] = d[8*i +: 8];
        n = (op == 8'h30) ? 2 + NB :
            (op == 8'h20 || op == 8'h31) ? 2 : 1;
        for (int i = 0; i < n; i++)
            send_byte(b[i], (i == n - 1) ? 0 : $urandom_range(0, gmax));
        if (op != 8'h00) begin
            @(posedge sys_clk);
            #1;
            model_apply(op, ch, d);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk(name, n < 400, 1'b1);
    endtask

    initial begin
        logic [7:0] ops [9];
        logic [7:0] op;
        ops = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h20, 8'h30, 8'h31, 8'h55};
        model_reset();
        #1 sys_rst_n = 1'b0;
        #2;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_out_pins", out_pins, '0);
        chk("rst_stb", out_wr_stb, '0);
        chk("rst_clk_rst", {out_clk, out_rst}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", rx_overrun, 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        run_cmp = 1'b1;
        repeat (2) begin @(posedge sys_clk); #1; end

        rdy_mode = 1;
        run_frame(8'h10, 8'h00, '0, 0);
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            chk("hold_valid", tx_valid, 1'b1);
            chk("hold_data", tx_data, 8'hA5);
        end
        rdy_mode = 2;
        wait_idle("drain_10");
        chk("out_clk_lit", out_clk, 1'b1);
        run_frame(8'h12, 8'h00, '0, 2);
        wait_idle("drain_12");
        chk("out_rst_lit", out_rst, 1'b1);

        rdy_mode = 0;
        run_frame(8'h30, 8'h03, 32'h12345678, 2);
        chk("wr3_lit", out_pins[3*DW +: DW], 32'h12345678);
        chk("stb3_lit", out_wr_stb, 8'h08);
        @(posedge sys_clk);
        #1;
        chk("stb3_clear", out_wr_stb, 8'h00);
        wait_idle("drain_30");

        run_frame(8'h31, 8'h03, '0, 2);
        chk("rb3_len", exp_q.size(), NB);
        chk("rb3_lit", q_word(), 32'h12345678);
        wait_idle("drain_31");

        in_pins[7*DW +: DW] = 32'hDEADBEEF;
        rdy_mode = 1;
        run_frame(8'h20, 8'h07, '0, 2);
        chk("rd7_lit", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]},
            32'hEFBEADDE);
        in_pins[7*DW +: DW] = 32'h0BADF00D;
        repeat (2) begin @(posedge sys_clk); #1; end
        rdy_mode = 0;
        wait_idle("drain_20");

        run_frame(8'h30, 8'h09, 32'hCAFEF00D, 2);
        chk("bad_ch_err", exp_q[0], 8'hEE);
        wait_idle("drain_30_bad");
        run_frame(8'h55, 8'h00, '0, 0);
        chk("bad_op_err", exp_q[0], 8'hEE);
        wait_idle("drain_55");
        run_frame(8'h00, 8'h00, '0, 0);
        repeat (4) begin
            chk("nop_busy", busy, 1'b0);
            @(posedge sys_clk);
            #1;
        end

        send_byte(8'h30, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        for (int i = 1; i < TMO; i++) begin
            @(posedge sys_clk);
            #1;
            chk("tmo_busy_hi", busy, 1'b1);
        end
        @(posedge sys_clk);
        #1;
        chk("tmo_busy_lo", busy, 1'b0);
        run_frame(8'h31, 8'h02, '0, 2);
        chk("tmo_rb_lit", q_word(), 32'h00000000);
        wait_idle("drain_tmo");

        rdy_mode = 1;
        run_frame(8'h20, 8'h07, '0, 0);
        send_byte(8'h13, 0);
        exp_ovr = 1'b1;
        @(posedge sys_clk);
        #1;
        rdy_mode = 2;
        wait_idle("drain_ovr");
        chk("ovr_rst_kept", out_rst, 1'b1);

        rdy_mode = 0;
        for (int k = 0; k < 60; k++) begin
            for (int c = 0; c < NCH; c++) in_pins[c*DW +: DW] = $urandom;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            run_frame(op, 8'($urandom_range(0, 9)), $urandom, 3);
            wait_idle("drain_rand");
        end

        run_frame(8'h10, 8'h00, '0, 0);
        wait_idle("drain_pre_rst");
        rdy_mode = 1;
        run_frame(8'h20, 8'h05, '0, 0);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_out_pins", out_pins, '0);
        chk("mid_rst_clk_rst", {out_clk, out_rst}, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        rdy_mode = 2;
        repeat (3) begin @(posedge sys_clk); #1; end
        run_frame(8'h31, 8'h03, '0, 1);
        chk("post_rst_rb", q_word(), 32'h00000000);
        wait_idle("drain_post_rst");

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
